// File: rtl/cpu_pkg.sv
// Shared types and constants for the accumulator CPU fetch/execute sequencer.
// The optional single-step feature is controlled by the SINGLE_STEP_EN macro.
package cpu_pkg;

    localparam int CPU_ADDR_W = 5;
    localparam int CPU_DATA_W = 8;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDA = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_STA = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_JMP = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        FWAIT  = 4'd2,
        DECODE = 4'd3,
        OPRD   = 4'd4,
        OPWAIT = 4'd5,
        WR     = 4'd6,
        HALT   = 4'd7,
        PAUSE  = 4'd8
    } state_t;

    // Opcodes that read a memory operand and update ACC.
    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == OP_LDA) || (op == OP_ADD) || (op == OP_AND) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/mem_fetch_exec_ctrl_seq_alu.sv
// Combinational accumulator ALU: LDA/ADD/AND/SUB result plus zero and carry/borrow.
module seq_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W
) (
    input  logic [2:0]        i_opcode,
    input  logic [DATA_W-1:0] i_acc,
    input  logic [DATA_W-1:0] i_operand,
    output logic [DATA_W-1:0] o_result,
    output logic              o_zero,
    output logic              o_carry
);

    logic [DATA_W:0] w_wide;

    // Extra top bit carries ADD carry-out or SUB borrow (set exactly when acc < operand).
    always_comb begin
        w_wide = {(DATA_W+1){1'b0}};
        case (i_opcode)
            OP_LDA:  w_wide = {1'b0, i_operand};
            OP_ADD:  w_wide = {1'b0, i_acc} + {1'b0, i_operand};
            OP_AND:  w_wide = {1'b0, i_acc & i_operand};
            OP_SUB:  w_wide = {1'b0, i_acc} - {1'b0, i_operand};
            default: w_wide = {1'b0, i_acc};
        endcase
    end

    assign o_result = w_wide[DATA_W-1:0];
    assign o_zero   = (w_wide[DATA_W-1:0] == {DATA_W{1'b0}});
    assign o_carry  = w_wide[DATA_W];

endmodule

// File: rtl/mem_fetch_exec_ctrl.sv
// Fetch/execute sequencer owning PC, IR and ACC and driving the shared program/data RAM.
// Define SINGLE_STEP_EN to add the step input and a PAUSE state after every instruction.
module mem_fetch_exec_ctrl
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = CPU_ADDR_W,
    parameter int DATA_W  = CPU_DATA_W,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
`ifdef SINGLE_STEP_EN
    input  logic              step,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] acc,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ir,
    output logic              zero,
    output logic              carry,
    output logic              busy,
    output logic              halted
);

    if ((MEM_LAT != 1) || (DATA_W != ADDR_W + 3)) begin : g_bad_cfg
        $error("mem_fetch_exec_ctrl: needs MEM_LAT==1 and DATA_W==ADDR_W+3");
    end

`ifdef SINGLE_STEP_EN
    localparam state_t DONE_ST = PAUSE;
`else
    localparam state_t DONE_ST = FETCH;
`endif

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc_nxt, r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0] r_ir, w_ir_nxt, r_acc, w_acc_nxt, r_mem_wdata;
    logic              r_zero, w_zero_nxt, r_carry, w_carry_nxt;
    logic              r_mem_rd, w_mem_rd_nxt, r_mem_wr, w_mem_wr_nxt;
    logic              r_busy, w_busy_nxt, r_halted, w_halted_nxt;
    logic [2:0]        w_opcode;
    logic [ADDR_W-1:0] w_opaddr;
    logic [DATA_W-1:0] w_alu_res;
    logic              w_alu_zero, w_alu_carry;

    assign w_opcode = r_ir[DATA_W-1 -: 3];
    assign w_opaddr = r_ir[ADDR_W-1:0];

    seq_alu #(.DATA_W(DATA_W)) u_alu (
        .i_opcode  (w_opcode),
        .i_acc     (r_acc),
        .i_operand (mem_rdata),
        .o_result  (w_alu_res),
        .o_zero    (w_alu_zero),
        .o_carry   (w_alu_carry)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; start only acts from IDLE or HALT.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:   if (start) w_state_nxt = FETCH; else w_state_nxt = IDLE;
            FETCH:  w_state_nxt = FWAIT;
            FWAIT:  w_state_nxt = DECODE;
            DECODE: begin
                case (w_opcode)
                    OP_LDA, OP_ADD, OP_AND, OP_SUB: w_state_nxt = OPRD;
                    OP_STA:  w_state_nxt = WR;
                    OP_HLT:  w_state_nxt = HALT;
                    default: w_state_nxt = DONE_ST;
                endcase
            end
            OPRD:   w_state_nxt = OPWAIT;
            OPWAIT: w_state_nxt = DONE_ST;
            WR:     w_state_nxt = DONE_ST;
            HALT:   if (start) w_state_nxt = FETCH; else w_state_nxt = HALT;
`ifdef SINGLE_STEP_EN
            PAUSE:  if (step) w_state_nxt = FETCH; else w_state_nxt = PAUSE;
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    // Architectural register updates (PC, IR, ACC, flags).
    always_comb begin
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        w_acc_nxt   = r_acc;
        w_zero_nxt  = r_zero;
        w_carry_nxt = r_carry;
        case (r_state)
            FWAIT: begin
                w_ir_nxt = mem_rdata;
                w_pc_nxt = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
            DECODE: if (w_opcode == OP_JMP) w_pc_nxt = w_opaddr; else w_pc_nxt = r_pc;
            OPWAIT: begin
                w_acc_nxt  = w_alu_res;
                w_zero_nxt = w_alu_zero;
                if ((w_opcode == OP_ADD) || (w_opcode == OP_SUB)) begin
                    w_carry_nxt = w_alu_carry;
                end else begin
                    w_carry_nxt = r_carry;
                end
            end
            HALT: if (start) w_pc_nxt = {ADDR_W{1'b0}}; else w_pc_nxt = r_pc;
            default: w_pc_nxt = r_pc;
        endcase
    end

    // Output decode from the state being entered, so every output comes straight from a flop.
    always_comb begin
        w_mem_addr_nxt = r_mem_addr;
        w_mem_rd_nxt   = 1'b0;
        w_mem_wr_nxt   = 1'b0;
        w_busy_nxt     = 1'b1;
        w_halted_nxt   = 1'b0;
        case (w_state_nxt)
            FETCH: begin
                w_mem_addr_nxt = w_pc_nxt;
                w_mem_rd_nxt   = 1'b1;
            end
            OPRD: begin
                w_mem_addr_nxt = w_opaddr;
                w_mem_rd_nxt   = 1'b1;
            end
            WR: begin
                w_mem_addr_nxt = w_opaddr;
                w_mem_wr_nxt   = 1'b1;
            end
            IDLE, PAUSE: w_busy_nxt = 1'b0;
            HALT: begin
                w_busy_nxt   = 1'b0;
                w_halted_nxt = 1'b1;
            end
            default: w_busy_nxt = 1'b1;
        endcase
    end

    // Datapath and output registers; async reset also kills a pending write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc        <= {ADDR_W{1'b0}};
            r_ir        <= {DATA_W{1'b0}};
            r_acc       <= {DATA_W{1'b0}};
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_mem_addr  <= {ADDR_W{1'b0}};
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_wdata <= {DATA_W{1'b0}};
            r_busy      <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_pc        <= w_pc_nxt;
            r_ir        <= w_ir_nxt;
            r_acc       <= w_acc_nxt;
            r_zero      <= w_zero_nxt;
            r_carry     <= w_carry_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_rd    <= w_mem_rd_nxt;
            r_mem_wr    <= w_mem_wr_nxt;
            r_mem_wdata <= w_acc_nxt;
            r_busy      <= w_busy_nxt;
            r_halted    <= w_halted_nxt;
        end
    end

    assign pc        = r_pc;
    assign ir        = r_ir;
    assign acc       = r_acc;
    assign zero      = r_zero;
    assign carry     = r_carry;
    assign mem_addr  = r_mem_addr;
    assign mem_rd    = r_mem_rd;
    assign mem_wr    = r_mem_wr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;
    assign halted    = r_halted;

endmodule

// File: tb/tb_mem_fetch_exec_ctrl.sv
// Bench for mem_fetch_exec_ctrl: a 32x8 synchronous RAM plus an instruction-level
// reference model that predicts architectural state at every instruction boundary.
module tb_mem_fetch_exec_ctrl;

`ifdef SINGLE_STEP_EN
    localparam bit STEP_EN = 1'b1;
    logic step;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, start;
    logic [4:0] mem_addr, pc;
    logic       mem_rd, mem_wr, zero, carry, busy, halted;
    logic [7:0] mem_wdata, acc, ir;
    logic [7:0] mem_rdata = 8'h00;

    always #5 clk = ~clk;

    mem_fetch_exec_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
`ifdef SINGLE_STEP_EN
        .step      (step),
`endif
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .acc       (acc),
        .pc        (pc),
        .ir        (ir),
        .zero      (zero),
        .carry     (carry),
        .busy      (busy),
        .halted    (halted)
    );

    // Program/data RAM; the bench loader port has priority over the CPU.
    logic [7:0] mem [0:31];
    logic       tb_we;
    logic [4:0] tb_addr;
    logic [7:0] tb_data;
    always @(posedge clk) begin
        if (tb_we) mem[tb_addr] <= tb_data;
        else if (mem_wr) mem[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    int n_checks = 0;
    int n_errors = 0;
    int wr_seen  = 0;
    int wr_base  = 0;

    // Reference model state.
    logic [7:0] img   [0:31];
    logic [7:0] m_mem [0:31];
    logic [4:0] m_pc;
    logic [7:0] m_ir, m_acc;
    logic       m_zero, m_carry;
    int         m_writes, m_cycles;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: mid-cycle invariants, then return #1 after the next rising edge.
    task automatic tick();
        @(negedge clk);
        chk("rd_wr_excl", 64'(mem_rd & mem_wr), 64'd0);
        chk("busy_halted_excl", 64'(busy & halted), 64'd0);
        chk("wdata_is_acc", 64'(mem_wdata), 64'(acc));
        if (reset) chk("outs_in_reset",
            64'({pc, ir, acc, zero, carry, mem_addr, mem_rd, mem_wr, mem_wdata, busy, halted}), 64'd0);
        if (mem_wr) wr_seen++;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pc = 5'd0; m_ir = 8'h00; m_acc = 8'h00; m_zero = 1'b0; m_carry = 1'b0;
    endtask

    // Executes one instruction at ISA level; returns its cycle count.
    task automatic model_step(output int cyc, output bit h);
        logic [7:0] d;
        logic [8:0] s;
        logic [4:0] a;
        m_ir = m_mem[m_pc];
        m_pc = m_pc + 5'd1;
        a = m_ir[4:0];
        d = m_mem[a];
        h = 1'b0;
        cyc = 5;
        case (m_ir[7:5])
            3'd0: cyc = 3;
            3'd1: begin m_acc = d; m_zero = (d == 8'h00); end
            3'd2: begin
                s = {1'b0, m_acc} + {1'b0, d};
                m_acc = s[7:0]; m_carry = s[8]; m_zero = (m_acc == 8'h00);
            end
            3'd3: begin m_mem[a] = m_acc; m_writes++; cyc = 4; end
            3'd4: begin m_acc = m_acc & d; m_zero = (m_acc == 8'h00); end
            3'd5: begin
                m_carry = (m_acc < d); m_acc = m_acc - d; m_zero = (m_acc == 8'h00);
            end
            3'd6: begin m_pc = a; cyc = 3; end
            default: begin h = 1'b1; cyc = 3; end
        endcase
        m_cycles += cyc;
    endtask

    task automatic load_img();
        for (int i = 0; i < 32; i++) begin
            tb_we = 1'b1; tb_addr = 5'(i); tb_data = img[i];
            tick();
        end
        tb_we = 1'b0;
        for (int i = 0; i < 32; i++) m_mem[i] = img[i];
        m_writes = 0; m_cycles = 0;
    endtask

    task automatic clear_img();
        for (int i = 0; i < 32; i++) img[i] = 8'h00;
    endtask

    task automatic pulse_start();
        wr_base = wr_seen;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Runs up to max_instr instructions, comparing DUT to the model at every boundary.
    task automatic run_model(input int max_instr, input bit noise, output bit h);
        int cyc;
        h = 1'b0;
        for (int k = 0; k < max_instr && !h; k++) begin
            model_step(cyc, h);
            for (int c = 0; c < cyc; c++) begin
                if (h && c == cyc - 1) chk("halted_early", 64'(halted), 64'd0);
                tick();
                if (noise && c < cyc - 1) start = 1'($urandom_range(0, 1));
                else start = 1'b0;
            end
            chk("pc", 64'(pc), 64'(m_pc));
            chk("ir", 64'(ir), 64'(m_ir));
            chk("acc", 64'(acc), 64'(m_acc));
            chk("zero", 64'(zero), 64'(m_zero));
            chk("carry", 64'(carry), 64'(m_carry));
            chk("halted", 64'(halted), 64'(h));
            chk("busy", 64'(busy), 64'(!h && !STEP_EN));
`ifdef SINGLE_STEP_EN
            if (!h) begin
                repeat (2) begin
                    tick();
                    chk("pause_holds", 64'(busy), 64'd0);
                end
                step = 1'b1;
                tick();
                step = 1'b0;
                chk("step_fetch", 64'({busy, mem_rd, mem_addr}), 64'({2'b11, m_pc}));
            end
`endif
        end
    endtask

    task automatic check_mem_and_writes(input string tag);
        for (int i = 0; i < 32; i++)
            chk($sformatf("%s_mem[%0d]", tag, i), 64'(mem[i]), 64'(m_mem[i]));
        chk({tag, "_write_count"}, 64'(wr_seen - wr_base), 64'(m_writes));
    endtask

    initial begin
        bit h;
        reset = 1'b1; start = 1'b0; tb_we = 1'b0; tb_addr = 5'd0; tb_data = 8'h00;
`ifdef SINGLE_STEP_EN
        step = 1'b0;
`endif
        tick(); tick();
        chk("reset_state", 64'({pc, ir, acc, zero, carry, mem_rd, mem_wr, busy, halted}), 64'd0);
        reset = 1'b0;
        tick();
        chk("idle_not_busy", 64'({busy, halted}), 64'd0);

        // Store/arithmetic program: LDA 11, ADD 12, STA 13, HLT.
        clear_img();
        img[0] = 8'h2B; img[1] = 8'h4C; img[2] = 8'h6D; img[3] = 8'hE0;
        img[11] = 8'h05; img[12] = 8'h03;
        load_img(); model_reset();
        pulse_start();
        run_model(10, 1'b1, h);
        chk("t1_model_cycles", 64'(m_cycles), 64'd17);
        chk("t1_mem13", 64'(mem[13]), 64'h08);
        chk("t1_acc_flags", 64'({acc, zero, carry}), 64'({8'h08, 2'b00}));
        chk("t1_pc", 64'(pc), 64'd4);
        chk("t1_halted", 64'(halted), 64'd1);
        check_mem_and_writes("t1");

        // Restart from HALT: pc returns to 0, acc kept.
        pulse_start();
        chk("restart_pc", 64'(pc), 64'd0);
        chk("restart_acc", 64'(acc), 64'h08);
        chk("restart_fetch0", 64'({mem_rd, mem_addr}), 64'({1'b1, 5'd0}));
        m_pc = 5'd0; m_writes = 0;
        run_model(10, 1'b1, h);
        check_mem_and_writes("t2");

        // SUB with borrow: 03 - 05.
        clear_img();
        img[0] = 8'h2B; img[1] = 8'hAC; img[2] = 8'hE0; img[11] = 8'h03; img[12] = 8'h05;
        load_img(); m_pc = 5'd0;
        pulse_start();
        run_model(10, 1'b1, h);
        chk("t3_sub", 64'({acc, carry, zero}), 64'({8'hFE, 2'b10}));

        // AND to zero: F0 & 0F, carry left at 1 from the SUB.
        clear_img();
        img[0] = 8'h2B; img[1] = 8'h8C; img[2] = 8'hE0; img[11] = 8'hF0; img[12] = 8'h0F;
        load_img(); m_pc = 5'd0;
        pulse_start();
        run_model(10, 1'b1, h);
        chk("t4_and", 64'({acc, zero, carry}), 64'({8'h00, 2'b11}));

        // JMP 31 / NOP at 31 loop with PC wrap; never writes.
        clear_img();
        img[0] = 8'hDF; img[31] = 8'h00;
        load_img(); m_pc = 5'd0;
        pulse_start();
        run_model(6, 1'b1, h);
        chk("t5_pc_wrapped", 64'({pc, ir}), 64'({5'd0, 8'h00}));
        chk("t5_no_writes", 64'(wr_seen - wr_base), 64'd0);

        // Reset during the WR cycle of STA aborts the write.
        reset = 1'b1; tick(); reset = 1'b0;
        clear_img();
        img[0] = 8'h2B; img[1] = 8'h6D; img[2] = 8'hE0; img[11] = 8'h55; img[13] = 8'hAA;
        load_img(); model_reset();
        pulse_start();
        run_model(1, 1'b0, h);
        repeat (3) tick();
        chk("t6_in_wr", 64'({mem_wr, mem_addr}), 64'({1'b1, 5'd13}));
        reset = 1'b1;
        #1;
        chk("t6_wr_aborted", 64'(mem_wr), 64'd0);
        chk("t6_outs_zero", 64'({pc, ir, acc, zero, carry, mem_addr, mem_rd, busy, halted}), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("t6_mem13_kept", 64'(mem[13]), 64'hAA);
        model_reset(); m_writes = 0;
        pulse_start();
        chk("t6_fetch_addr0", 64'({busy, mem_rd, mem_addr}), 64'({2'b11, 5'd0}));
        run_model(10, 1'b1, h);
        check_mem_and_writes("t6");

        // Random programs from reset.
        for (int r = 0; r < 6; r++) begin
            reset = 1'b1; tick(); reset = 1'b0;
            for (int i = 0; i < 32; i++) img[i] = 8'($urandom);
            load_img(); model_reset();
            pulse_start();
            run_model(25, 1'b1, h);
            check_mem_and_writes($sformatf("rnd%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_fetch_exec_ctrl.md
Name: mem_fetch_exec_ctrl

Overview:
Fetch/execute sequencer for the simple accumulator CPU. It owns the program counter (PC), instruction register (IR) and accumulator (ACC), and drives the shared 32x8 synchronous program/data memory through one read/write port. It fetches each instruction, decodes the 3-bit opcode and 5-bit address, then issues operand reads, ALU updates or stores. It sits between the top level (start/status) and the memory block.

Parameters:
ADDR_W, 5, memory address width; PC width; instruction address field width
DATA_W, 8, memory word, IR and ACC width; must equal ADDR_W+3
MEM_LAT, 1, memory read latency in cycles; only 1 is supported

Ports:
clk  in  1  clock, all state changes on the rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins execution from IDLE or HALT
mem_addr  out  ADDR_W  memory address
mem_rd  out  1  read strobe; data is valid on mem_rdata the following cycle
mem_wr  out  1  write strobe; memory writes mem_wdata at this edge
mem_wdata  out  DATA_W  store data, equal to ACC
mem_rdata  in  DATA_W  registered memory read data
acc  out  DATA_W  accumulator
pc  out  ADDR_W  program counter
ir  out  DATA_W  instruction register
zero  out  1  set when the last ALU result was 0
carry  out  1  ADD carry-out / SUB borrow
busy  out  1  high in every state except IDLE and HALT
halted  out  1  high in HALT

Behaviour:
- Reset (asynchronous): state=IDLE. pc, ir, acc, zero, carry, mem_addr, mem_rd, mem_wr and mem_wdata all 0.
- Reset mid-operation aborts any pending write: mem_wr is low while reset is high.
- Outputs derive from registered state/regs only; no combinational path from mem_rdata to any output.
- Instruction format: [7:5] opcode, [4:0] operand address.
- Opcodes: 000 NOP, 001 LDA, 010 ADD, 011 STA, 100 AND, 101 SUB, 110 JMP, 111 HLT.
- States and transitions:
  - IDLE: wait for start, then go to FETCH.
  - FETCH: mem_addr=pc, mem_rd=1. Next state FWAIT.
  - FWAIT: ir<=mem_rdata, pc<=pc+1 (mod 32, so 31 wraps to 0). Next state DECODE.
  - DECODE:
    - LDA/ADD/AND/SUB go to OPRD.
    - STA goes to WR.
    - JMP sets pc<=ir[4:0] and goes to FETCH.
    - NOP goes to FETCH.
    - HLT goes to HALT.
  - OPRD: mem_addr=ir[4:0], mem_rd=1. Next state OPWAIT.
  - OPWAIT: ACC updated from mem_rdata:
    - LDA: acc=d.
    - ADD: {carry,acc}=acc+d.
    - AND: acc=acc&d.
    - SUB: acc=acc-d mod 256, carry=(acc<d).
    - zero updates on all four opcodes; carry updates only on ADD/SUB.
    - Next state FETCH.
  - WR: mem_addr=ir[4:0], mem_wr=1, mem_wdata=acc. Next state FETCH.
  - HALT: hold all registers. On start: pc<=0, acc and flags preserved, go to FETCH.
- Cycles per instruction:
  - LDA/ADD/AND/SUB: 5.
  - STA: 4.
  - NOP/JMP: 3.
  - HLT: 3 cycles to reach HALT.
- start is ignored while busy.
- mem_rd and mem_wr are never high together.
- STA to the address being executed is allowed; the new value is seen on the next fetch of that address.

Optional Feature:
SINGLE_STEP_EN:
- Defined: adds input port step (1 bit) and a PAUSE state. Every path that would return to FETCH after an instruction completes goes to PAUSE instead. PAUSE moves to FETCH on step=1. busy is low in PAUSE. reset leaves PAUSE immediately. The first fetch after start is not gated.
- Undefined: no step port, no PAUSE state; execution is free-running.

Decomposition:
- Package cpu_pkg holds:
  - opcode localparams (OP_NOP..OP_HLT)
  - state enum typedef (IDLE, FETCH, FWAIT, DECODE, OPRD, OPWAIT, WR, HALT, PAUSE)
  - ADDR_W/DATA_W defaults
- One combinational sub-module, seq_alu: opcode, acc and operand in; result, zero and carry out.

Test Plan:
- Store/arithmetic program:
  - Memory: mem[0..3]=2B,4C,6D,E0; mem[11]=05; mem[12]=03. Pulse start.
  - Expect mem[13]=08, acc=08, zero=0, carry=0, pc=4.
  - halted rises exactly 17 cycles after start.
- SUB with borrow:
  - acc=03 (loaded by LDA), then SUB of operand 05.
  - Expect acc=FE, carry=1, zero=0.
- AND to zero:
  - LDA of F0, then AND of 0F.
  - Expect acc=00, zero=1, carry unchanged.
- JMP and PC wrap:
  - mem[0]=DF (JMP 31), mem[31]=00 (NOP).
  - pc after each FWAIT follows 1, 31→0 wrap, 1. Program loops; mem_wr never asserted.
- Reset in WR:
  - Assert reset during the STA WR cycle.
  - mem_wr falls immediately, target word unchanged, all outputs 0, state IDLE.
  - A following start fetches from address 0.
- Halt restart and single step:
  - From HALT with acc=08, pulse start: pc=0, acc stays 08.
  - With SINGLE_STEP_EN: controller stops in PAUSE after each instruction; each step pulse advances exactly one instruction.
